// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi decoder front-end control.
// Holds the frame FSM state encoding, trellis stage codes and pair width.
// Imported by bmu_frame_ctrl.
package viterbi_pkg;

  localparam int PAIR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIRST     = 3'd1,
    ST_SECOND    = 3'd2,
    ST_STEADY    = 3'd3,
    ST_TRACEBACK = 3'd4
  } frame_state_t;

  localparam logic [1:0] STAGE_FIRST  = 2'd0;
  localparam logic [1:0] STAGE_SECOND = 2'd1;
  localparam logic [1:0] STAGE_STEADY = 2'd2;

endpackage

// File: rtl/bmu_frame_ctrl.sv
// Frame controller feeding received pairs to the branch-metric pipeline and launching traceback.
// Latency: accepted pair appears on bmu_* one cycle later; in_ready is combinational from state only.
// Optional traceback watchdog enabled by defining BMU_FRAME_CTRL_WDOG_EN (tb_timeout tied 0 otherwise).
module bmu_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN  = 16,
  parameter int TB_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PAIR_W-1:0] in_pair,
  output logic              in_ready,
  input  logic              tb_done,
  output logic              bmu_valid,
  output logic [PAIR_W-1:0] bmu_pair,
  output logic [1:0]        bmu_stage,
  output logic [7:0]        sym_cnt,
  output logic              tb_start,
  output logic              frame_done,
  output logic              busy,
  output logic              tb_timeout
);

  // Reject parameter values the counters cannot represent.
  if (FRAME_LEN < 3 || FRAME_LEN > 255 || TB_TIMEOUT < 1) begin : g_bad_cfg
    $error("bmu_frame_ctrl: FRAME_LEN must be 3..255 and TB_TIMEOUT >= 1");
  end

  frame_state_t state;

  // The last pair of a frame is the one that brings sym_cnt up to FRAME_LEN.
  logic last_pair;
  assign last_pair = (sym_cnt == 8'(FRAME_LEN - 1));

  // Pairs are only taken while the trellis is being filled or running steady.
  assign in_ready = (state == ST_FIRST) || (state == ST_SECOND) || (state == ST_STEADY);
  assign busy     = (state != ST_IDLE);

`ifdef BMU_FRAME_CTRL_WDOG_EN
  localparam int WD_W = (TB_TIMEOUT > 1) ? $clog2(TB_TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;

  // Expiry is the TB_TIMEOUT-th traceback cycle; tb_done in that cycle still wins.
  assign wd_expire = (wd_cnt == WD_W'(TB_TIMEOUT - 1));

  // Count traceback cycles; restart from zero whenever traceback is not active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == ST_TRACEBACK && !tb_done && !wd_expire) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign tb_timeout = 1'b0;
`endif

  // Frame FSM with registered pair forwarding, symbol count and completion pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bmu_valid  <= 1'b0;
      bmu_pair   <= '0;
      bmu_stage  <= STAGE_FIRST;
      sym_cnt    <= 8'd0;
      tb_start   <= 1'b0;
      frame_done <= 1'b0;
`ifdef BMU_FRAME_CTRL_WDOG_EN
      tb_timeout <= 1'b0;
`endif
    end else begin
      bmu_valid  <= 1'b0;
      tb_start   <= 1'b0;
      frame_done <= 1'b0;
`ifdef BMU_FRAME_CTRL_WDOG_EN
      tb_timeout <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_FIRST;
            sym_cnt <= 8'd0;
          end
        end
        ST_FIRST: begin
          if (in_valid) begin
            bmu_valid <= 1'b1;
            bmu_pair  <= in_pair;
            bmu_stage <= STAGE_FIRST;
            sym_cnt   <= sym_cnt + 8'd1;
            state     <= ST_SECOND;
          end
        end
        ST_SECOND: begin
          if (in_valid) begin
            bmu_valid <= 1'b1;
            bmu_pair  <= in_pair;
            bmu_stage <= STAGE_SECOND;
            sym_cnt   <= sym_cnt + 8'd1;
            state     <= ST_STEADY;
          end
        end
        ST_STEADY: begin
          if (in_valid) begin
            bmu_valid <= 1'b1;
            bmu_pair  <= in_pair;
            bmu_stage <= STAGE_STEADY;
            sym_cnt   <= sym_cnt + 8'd1;
            if (last_pair) begin
              state    <= ST_TRACEBACK;
              tb_start <= 1'b1;
            end
          end
        end
        ST_TRACEBACK: begin
          // A concurrent start is not carried over; it must be re-issued in IDLE.
          if (tb_done) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
`ifdef BMU_FRAME_CTRL_WDOG_EN
          else if (wd_expire) begin
            state      <= ST_IDLE;
            tb_timeout <= 1'b1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_frame_ctrl.sv
module tb_bmu_frame_ctrl;

  localparam int FRAME_LEN  = 16;
  localparam int TB_TIMEOUT = 64;
`ifdef BMU_FRAME_CTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_pair = 2'b00;
  logic       tb_done = 1'b0;
  logic       in_ready, bmu_valid, tb_start, frame_done, busy, tb_timeout;
  logic [1:0] bmu_pair, bmu_stage;
  logic [7:0] sym_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  bmu_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .TB_TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_pair(in_pair),
    .in_ready(in_ready), .tb_done(tb_done), .bmu_valid(bmu_valid), .bmu_pair(bmu_pair),
    .bmu_stage(bmu_stage), .sym_cnt(sym_cnt), .tb_start(tb_start), .frame_done(frame_done),
    .busy(busy), .tb_timeout(tb_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: frame phase + pair count ----------------
  // phase: 0 = waiting for start, 1 = collecting pairs, 2 = waiting for traceback
  int         m_phase;
  int         m_n;
  int         m_tbc;
  logic       e_valid, e_tbstart, e_fdone, e_tmo;
  logic [1:0] e_pair, e_stage;
  logic [7:0] e_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_tbc = 0;
      e_valid = 0; e_tbstart = 0; e_fdone = 0; e_tmo = 0;
      e_pair = 0; e_stage = 0; e_cnt = 0;
    end else begin
      e_valid = 0; e_tbstart = 0; e_fdone = 0; e_tmo = 0;
      if (m_phase == 0) begin
        if (start) begin m_phase = 1; m_n = 0; e_cnt = 0; end
      end else if (m_phase == 1) begin
        if (in_valid) begin
          e_valid = 1;
          e_pair  = in_pair;
          e_stage = (m_n == 0) ? 2'd0 : (m_n == 1) ? 2'd1 : 2'd2;
          m_n++;
          e_cnt = 8'(m_n);
          if (m_n == FRAME_LEN) begin m_phase = 2; m_tbc = 0; e_tbstart = 1; end
        end
      end else begin
        m_tbc++;
        if (tb_done) begin m_phase = 0; e_fdone = 1; end
        else if (WDOG && m_tbc == TB_TIMEOUT) begin m_phase = 0; e_tmo = 1; end
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", in_ready, m_phase == 1);
      check("m_busy", busy, m_phase != 0);
      check("m_bmu_valid", bmu_valid, e_valid);
      check("m_sym_cnt", sym_cnt, e_cnt);
      check("m_tb_start", tb_start, e_tbstart);
      check("m_frame_done", frame_done, e_fdone);
      check("m_tb_timeout", tb_timeout, e_tmo);
      if (e_valid) begin
        check("m_bmu_pair", bmu_pair, e_pair);
        check("m_bmu_stage", bmu_stage, e_stage);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_zero"}, {in_ready, bmu_valid, bmu_pair, bmu_stage, sym_cnt,
                           tb_start, frame_done, busy, tb_timeout}, 0);
  endtask

  initial begin
    int  seen;
    bit  tmo_seen;

    // ---- reset state ----
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    check_all_zero("idle");

    // ---- full frame of 16 x 2'b11 ----
    start = 1'b1; tick(); start = 1'b0;
    check("first_in_ready", in_ready, 1);
    in_valid = 1'b1; in_pair = 2'b11;
    for (int i = 0; i < FRAME_LEN; i++) begin
      tick();
      check("f1_valid", bmu_valid, 1);
      check("f1_stage", bmu_stage, (i == 0) ? 0 : (i == 1) ? 1 : 2);
      check("f1_tb_start", tb_start, i == FRAME_LEN - 1);
    end
    in_valid = 1'b0;
    check("f1_sym_cnt", sym_cnt, 16);
    check("f1_in_ready", in_ready, 0);

    // ---- tb_done + start together on 5th traceback cycle ----
    for (int i = 0; i < 4; i++) tick();
    tb_done = 1'b1; start = 1'b1;
    tick();
    tb_done = 1'b0;
    check("done_frame_done", frame_done, 1);
    check("done_busy", busy, 0);
    // start held during the frame_done cycle opens the next frame
    tick();
    start = 1'b0;
    check("b2b_in_ready", in_ready, 1);
    check("b2b_sym_cnt", sym_cnt, 0);

    // ---- toggled valid with pairs 00,01,10,11 ----
    for (int k = 0; k < 8; k++) begin
      in_valid = (k % 2 == 0);
      in_pair  = 2'(k / 2);
      tick();
      check("tog_valid", bmu_valid, (k % 2 == 0));
      if (k % 2 == 0) check("tog_pair", bmu_pair, k / 2);
    end
    in_valid = 1'b0;
    check("tog_sym_cnt", sym_cnt, 4);

    // ---- reset after 7 pairs ----
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin in_pair = 2'($urandom_range(0, 3)); tick(); end
    in_valid = 1'b0;
    check("pre_rst_sym_cnt", sym_cnt, 7);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    tick();
    rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_pair = 2'b10;
    tick();
    check("rst_restart_stage", bmu_stage, 0);
    check("rst_restart_cnt", sym_cnt, 1);
    for (int k = 1; k < FRAME_LEN; k++) begin in_pair = 2'($urandom_range(0, 3)); tick(); end
    in_valid = 1'b0;
    check("wd_tb_start", tb_start, 1);

    // ---- traceback without tb_done ----
    seen = 0; tmo_seen = 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (tb_timeout === 1'b1 && !tmo_seen) begin tmo_seen = 1; seen = c; end
      if (tmo_seen) break;
    end
    if (WDOG) begin
      check("wd_expiry_cycle", seen, 64);
      check("wd_busy", busy, 0);
      tick();
      check("wd_pulse_once", tb_timeout, 0);
      // tb_done in the expiry cycle wins
      start = 1'b1; tick(); start = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < FRAME_LEN; k++) tick();
      in_valid = 1'b0;
      for (int k = 1; k < TB_TIMEOUT; k++) tick();
      tb_done = 1'b1; tick(); tb_done = 1'b0;
      check("tie_frame_done", frame_done, 1);
      check("tie_tb_timeout", tb_timeout, 0);
    end else begin
      check("nowd_no_timeout", tmo_seen, 0);
      check("nowd_busy", busy, 1);
      check("nowd_in_ready", in_ready, 0);
      tb_done = 1'b1; tick(); tb_done = 1'b0;
      check("nowd_frame_done", frame_done, 1);
    end

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 3) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_pair  = 2'($urandom_range(0, 3));
      tb_done  = ($urandom_range(0, 39) == 0);
      tick();
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    start = 1'b0; in_valid = 1'b0; tb_done = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmu_frame_ctrl.md
BMU_FRAME_CTRL -- requirements
Module: bmu_frame_ctrl

Interface
REQ-001 Parameter FRAME_LEN, default 16: received symbol pairs per frame; legal range 3..255.
REQ-002 Parameter TB_TIMEOUT, default 64: traceback watchdog limit in cycles; used only under REQ-030.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  frame start request; sampled only in IDLE.
REQ-006 in_valid  input  1  in_pair is valid.
REQ-007 in_pair  input  2  received code bit pair; bit 1 is the first code bit.
REQ-008 in_ready  output  1  controller accepts in_pair this cycle.
REQ-009 tb_done  input  1  traceback unit has finished the frame.
REQ-010 bmu_valid  output  1  bmu_pair/bmu_stage are valid this cycle.
REQ-011 bmu_pair  output  2  bit pair forwarded to the branch-metric pipeline.
REQ-012 bmu_stage  output  2  trellis stage: 0 = first stage (2 metrics), 1 = second stage (4 metrics), 2 = steady stage (8 metrics); 3 is never driven.
REQ-013 sym_cnt  output  8  number of pairs accepted in the current frame.
REQ-014 tb_start  output  1  one-cycle pulse that launches traceback.
REQ-015 frame_done  output  1  one-cycle pulse at frame completion.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 tb_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-018 FSM states: IDLE, FIRST, SECOND, STEADY, TRACEBACK.
REQ-019 Outputs are registered; an accepted pair (in_valid && in_ready) drives bmu_valid=1 on the next cycle with that pair and the stage of the accepting state. The non-accepting cycle after a pair drives bmu_valid=0.
REQ-020 in_ready = 1 in FIRST, SECOND and STEADY; 0 in IDLE and TRACEBACK; it is combinational from state only.
REQ-021 IDLE: start=1 moves to FIRST and clears sym_cnt to 0; in_valid in IDLE is ignored.
REQ-022 FIRST: the accepted pair increments sym_cnt and moves to SECOND. SECOND: the accepted pair increments sym_cnt and moves to STEADY.
REQ-023 STEADY: each accepted pair increments sym_cnt. Accepting the pair that makes sym_cnt = FRAME_LEN moves to TRACEBACK.
REQ-024 If in_valid=0, state and sym_cnt hold and bmu_valid=0 the next cycle; gaps of any length are legal.
REQ-025 tb_start pulses in the first TRACEBACK cycle, coincident with the last bmu_valid of the frame.
REQ-026 TRACEBACK: tb_done=1 moves to IDLE and pulses frame_done on the next cycle. sym_cnt holds until the next start.
REQ-027 tb_done outside TRACEBACK and start outside IDLE are ignored. start and tb_done together in TRACEBACK complete the frame only; start must be re-asserted in IDLE.
REQ-028 The earliest back-to-back frame is a start in the cycle frame_done is high.

Reset
REQ-029 rst forces IDLE and clears all outputs to 0, including in_ready, bmu_valid, bmu_pair, bmu_stage, sym_cnt and all pulses. Reset mid-frame discards the frame with no frame_done and no tb_start.

Configuration
REQ-030 Macro BMU_FRAME_CTRL_WDOG_EN present: a cycle counter runs in TRACEBACK. If TB_TIMEOUT cycles elapse without tb_done, the controller moves to IDLE and pulses tb_timeout, with no frame_done. tb_done in the expiry cycle wins: frame_done pulses and tb_timeout does not.
REQ-031 Macro absent: no counter is built, tb_timeout is tied 0, and TRACEBACK waits indefinitely.

Structure
REQ-032 Package viterbi_pkg holds the FSM state enum, the stage codes STAGE_FIRST=0, STAGE_SECOND=1 and STAGE_STEADY=2, and the pair width constant 2.
REQ-033 There is no sub-module; the FSM, the symbol counter and the watchdog counter are inline.

Verification
REQ-034 Reset, then start, then 16 consecutive valid pairs of 2'b11 -> bmu_stage sequence 0,1,2x14; tb_start pulses with the 16th bmu_valid; sym_cnt=16; in_ready=0.
REQ-035 Pairs with in_valid toggled 1,0,1,0 -> bmu_valid mirrors the pattern delayed one cycle, and pairs 00,01,10,11 appear in order.
REQ-036 tb_done asserted 5 cycles into TRACEBACK together with start -> frame_done one cycle later, state IDLE, no new frame; start the next cycle -> FIRST with sym_cnt=0.
REQ-037 rst asserted after 7 pairs -> all outputs 0 immediately; a following start restarts at stage 0.
REQ-038 WDOG_EN with TB_TIMEOUT=64 and no tb_done -> tb_timeout pulses once after 64 TRACEBACK cycles, then IDLE; without the macro -> still TRACEBACK at cycle 200.
